stall_ctrl: RTL and testbench

//  Pipeline stall sequencer for the 5-stage MIPS core. Collects stall requests from ID
//  (load-use), EX (multi-cycle divide) and MEM (data SRAM wait), sequences the divider

---
 rtl/stall_ctrl.sv | 138 +++++++++++++
 tb/tb_stall_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline stall sequencer for the 5-stage core.
// Merges load-use, divide and data-SRAM stall requests into one StallBus.
// The sequencer also times the multi-cycle divide.
// Optional build macro: STALL_PERF_CNT_EN adds three 32-bit stall-cycle counters.
module stall_ctrl #(
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stallreq_for_load,
    input  logic       div_start,
    input  logic       stallreq_mem,
    output logic [5:0] stall,
    output logic       div_done,
    output logic       busy
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0] perf_load,
    output logic [31:0] perf_div,
    output logic [31:0] perf_mem
`endif
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_LD_BUB   = 2'd1;
    localparam logic [1:0] S_DIV_RUN  = 2'd2;
    localparam logic [1:0] S_DIV_WAIT = 2'd3;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_LOAD = 6'b000111;
    localparam logic [5:0] STALL_DIV  = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    // The start cycle itself is one of the DIV_CYCLES occupancy cycles,
    // so the counter is loaded with one less than the total.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             load_cause, div_cause, mem_cause;
    logic             div_done_next;
    logic [5:0]       stall_next;

    // Next-state, counter and stall-cause decode
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        load_cause    = 1'b0;
        div_cause     = 1'b0;
        div_done_next = 1'b0;
        mem_cause     = stallreq_mem;
        case (state_reg)
            S_IDLE, S_LD_BUB: begin
                // A divide takes precedence over a load-use request; the
                // divider starts even under a MEM stall because it free-runs.
                // In LD_BUB the load request is dropped: one bubble is enough.
                if (div_start) begin
                    div_cause  = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = S_DIV_RUN;
                end else if (state_reg == S_IDLE && stallreq_for_load) begin
                    // Under a MEM stall the bubble is deferred: the load
                    // consumer is frozen anyway and will ask again.
                    if (!stallreq_mem) begin
                        load_cause = 1'b1;
                        state_next = S_LD_BUB;
                    end
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_DIV_RUN: begin
                cnt_next = (cnt_reg != '0) ? cnt_reg - 1'b1 : '0;
                if (cnt_reg != '0) begin
                    div_cause = 1'b1;
                end else begin
                    div_done_next = 1'b1;
                    state_next    = stallreq_mem ? S_DIV_WAIT : S_IDLE;
                end
            end
            S_DIV_WAIT: begin
                // Result stays valid until the pipeline can accept it.
                div_done_next = 1'b1;
                if (!stallreq_mem) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Highest-priority cause selects the bus encoding: MEM > DIV > LOAD
    always_comb begin
        stall_next = STALL_NONE;
        if (mem_cause)       stall_next = STALL_MEM;
        else if (div_cause)  stall_next = STALL_DIV;
        else if (load_cause) stall_next = STALL_LOAD;
    end

    // Outputs are forced quiet while reset is asserted
    always_comb begin
        stall    = rst ? stall_next : STALL_NONE;
        div_done = rst & div_done_next;
        busy     = rst & (state_reg != S_IDLE);
    end

    // Sequencer state and divide counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [31:0] perf_load_reg, perf_div_reg, perf_mem_reg;

    // Stall-cycle counters keyed on the final bus encoding
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_load_reg <= '0;
            perf_div_reg  <= '0;
            perf_mem_reg  <= '0;
        end else begin
            if (stall_next == STALL_LOAD) perf_load_reg <= perf_load_reg + 32'd1;
            if (stall_next == STALL_DIV)  perf_div_reg  <= perf_div_reg + 32'd1;
            if (stall_next == STALL_MEM)  perf_mem_reg  <= perf_mem_reg + 32'd1;
        end
    end

    assign perf_load = perf_load_reg;
    assign perf_div  = perf_div_reg;
    assign perf_mem  = perf_mem_reg;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed testbench for stall_ctrl with DIV_CYCLES=33.
// Inputs change 1 ns after a rising edge; outputs are checked 2 ns later.
module tb_stall_ctrl;

    logic       clk;
    logic       rst;
    logic       stallreq_for_load;
    logic       div_start;
    logic       stallreq_mem;
    logic [5:0] stall;
    logic       div_done;
    logic       busy;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] perf_load, perf_div, perf_mem;
`endif

    int errors = 0;
    int checks = 0;

    stall_ctrl #(.DIV_CYCLES(33), .CNT_W(6)) dut (
        .clk               (clk),
        .rst               (rst),
        .stallreq_for_load (stallreq_for_load),
        .div_start         (div_start),
        .stallreq_mem      (stallreq_mem),
        .stall             (stall),
        .div_done          (div_done),
        .busy              (busy)
`ifdef STALL_PERF_CNT_EN
        ,
        .perf_load         (perf_load),
        .perf_div          (perf_div),
        .perf_mem          (perf_mem)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Move to the next cycle: inputs may be changed right after this returns.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; stallreq_for_load = 1'b1; div_start = 1'b1; stallreq_mem = 1'b1;
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (stall !== 6'b000000 || div_done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d: stall=%b done=%b busy=%b, expected 000000/0/0", i, stall, div_done, busy);
            end
            next_cycle();
        end
        rst = 1'b1; stallreq_for_load = 1'b0; div_start = 1'b0; stallreq_mem = 1'b0;
        #2;
        checks++;
        if (stall !== 6'b000000 || div_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: stall=%b done=%b busy=%b, expected 000000/0/0", stall, div_done, busy);
        end
        $display("test_reset done");
        next_cycle();
    endtask

    task automatic test_load_use();
        logic [5:0] exp_stall [3];
        logic       exp_busy  [3];
        logic       load_in   [3];
        exp_stall = '{6'b000111, 6'b000000, 6'b000000};
        exp_busy  = '{1'b0, 1'b1, 1'b0};
        load_in   = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            stallreq_for_load = load_in[i];
            #2;
            checks++;
            if (stall !== exp_stall[i] || busy !== exp_busy[i] || div_done !== 1'b0) begin
                errors++;
                $display("FAIL load_use cyc=%0d: stall=%b busy=%b done=%b, expected %b/%b/0", i, stall, busy, div_done, exp_stall[i], exp_busy[i]);
            end
            next_cycle();
        end
        $display("test_load_use done");
    endtask

    task automatic test_divide();
        logic [5:0] exp_stall;
        logic       exp_done;
        // Cycle k relative to the first div_start cycle t.
        for (int k = 0; k <= 34; k++) begin
            div_start = (k <= 33);
            exp_stall = (k <= 32) ? 6'b001111 : 6'b000000;
            exp_done  = (k == 33);
            #2;
            checks++;
            if (stall !== exp_stall || div_done !== exp_done) begin
                errors++;
                $display("FAIL divide t+%0d: stall=%b done=%b, expected %b/%b", k, stall, div_done, exp_stall, exp_done);
            end
            next_cycle();
        end
        checks++;
        #2;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL divide_idle: busy=%b, expected 0", busy);
        end
        $display("test_divide done");
    endtask

    task automatic test_back_to_back();
        // Second divide starts right after the first has left.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k <= 33; k++) begin
                div_start = 1'b1;
                #2;
                checks++;
                if (stall[3] !== (k <= 32) || div_done !== (k == 33)) begin
                    errors++;
                    $display("FAIL back_to_back run=%0d t+%0d: stall=%b done=%b, expected bit3=%0d done=%0d", r, k, stall, div_done, (k <= 32), (k == 33));
                end
                next_cycle();
            end
        end
        div_start = 1'b0;
        next_cycle();
        $display("test_back_to_back done");
    endtask

    task automatic test_div_mem();
        logic [5:0] exp_stall;
        logic       exp_done;
        for (int k = 0; k <= 38; k++) begin
            div_start    = (k <= 37);
            stallreq_mem = (k >= 31 && k <= 36);
            if (k >= 31 && k <= 36)  exp_stall = 6'b011111;
            else if (k <= 30)        exp_stall = 6'b001111;
            else                     exp_stall = 6'b000000;
            exp_done = (k >= 33 && k <= 37);
            #2;
            checks++;
            if (stall !== exp_stall || div_done !== exp_done) begin
                errors++;
                $display("FAIL div_mem t+%0d: stall=%b done=%b, expected %b/%b", k, stall, div_done, exp_stall, exp_done);
            end
            if (k == 38) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL div_mem_idle: busy=%b, expected 0", busy);
                end
            end
            next_cycle();
        end
        div_start = 1'b0;
        $display("test_div_mem done");
    endtask

    task automatic test_priority();
        // Load and divide together: divide wins, no bubble state.
        stallreq_for_load = 1'b1; div_start = 1'b1;
        #2;
        checks++;
        if (stall !== 6'b001111) begin
            errors++;
            $display("FAIL prio_div_over_load: stall=%b, expected 001111", stall);
        end
        next_cycle();
        stallreq_for_load = 1'b0;
        #2;
        checks++;
        if (stall !== 6'b001111 || busy !== 1'b1) begin
            errors++;
            $display("FAIL prio_div_run: stall=%b busy=%b, expected 001111/1", stall, busy);
        end
        // Abandon the divide to get back to IDLE.
        rst = 1'b0; div_start = 1'b0;
        next_cycle();
        rst = 1'b1;
        // MEM over load: stays in IDLE and retries.
        stallreq_for_load = 1'b1; stallreq_mem = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++;
            if (stall !== 6'b011111 || busy !== 1'b0) begin
                errors++;
                $display("FAIL prio_mem_over_load cyc=%0d: stall=%b busy=%b, expected 011111/0", i, stall, busy);
            end
            next_cycle();
        end
        stallreq_mem = 1'b0;
        #2;
        checks++;
        if (stall !== 6'b000111) begin
            errors++;
            $display("FAIL prio_load_retry: stall=%b, expected 000111", stall);
        end
        next_cycle();
        stallreq_for_load = 1'b0;
        next_cycle();
        $display("test_priority done");
    endtask

    task automatic test_abort();
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        div_start = 1'b1;
        for (int k = 0; k < 10; k++) next_cycle();
        // Now at t+10, still before the reset edge.
`ifdef STALL_PERF_CNT_EN
        #2;
        checks++;
        if (perf_div !== 32'd10 || perf_load !== 32'd0 || perf_mem !== 32'd0) begin
            errors++;
            $display("FAIL abort_perf: div=%0d load=%0d mem=%0d, expected 10/0/0", perf_div, perf_load, perf_mem);
        end
`endif
        rst = 1'b0;
        #2;
        checks++;
        if (stall !== 6'b000000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_forced: stall=%b busy=%b, expected 000000/0", stall, busy);
        end
        next_cycle();
        rst = 1'b1; div_start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            #2;
            checks++;
            if (div_done !== 1'b0 || busy !== 1'b0 || stall !== 6'b000000) begin
                errors++;
                $display("FAIL abort_no_done cyc=%0d: done=%b busy=%b stall=%b, expected 0/0/000000", k, div_done, busy, stall);
            end
            next_cycle();
        end
        $display("test_abort done");
    endtask

    initial begin
        rst = 1'b0; stallreq_for_load = 1'b0; div_start = 1'b0; stallreq_mem = 1'b0;
        test_reset();
        test_load_use();
        test_divide();
        test_back_to_back();
        test_div_mem();
        test_priority();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
